// File: rtl/exception_mult_pipe.sv
// Exception handling back end for an IEEE-style multiplier.
// Classifies the operands, overrides the datapath product for special
// inputs, overflow and underflow, and produces the result flags and status.
// Two-stage valid/ready pipeline with a sticky status accumulator.
module exception_mult_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    localparam int unsigned W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] z_calc,
    input  logic [2:0]   round,
    input  logic         inexact_in,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic         ovf,
    output logic         unf,
    output logic         inexact,
    output logic [7:0]   status,
    output logic [7:0]   sticky_status,
    input  logic         sticky_clr
);

    // Canonical quiet NaN: positive sign, all-ones exponent, mantissa MSB set.
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    // ------------------------------------------------------------------
    // Operand classification (input side)
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] w_a_exp;
    logic [EXP_W-1:0] w_b_exp;
    logic [MAN_W-1:0] w_a_man;
    logic [MAN_W-1:0] w_b_man;
    logic             w_a_zero;
    logic             w_b_zero;
    logic             w_a_inf;
    logic             w_b_inf;
    logic             w_a_nan;
    logic             w_b_nan;
    logic             w_sign;

    assign w_a_exp = a[W-2 -: EXP_W];
    assign w_b_exp = b[W-2 -: EXP_W];
    assign w_a_man = a[MAN_W-1:0];
    assign w_b_man = b[MAN_W-1:0];

    // Subnormals (zero exponent, any mantissa) are flushed and count as zero.
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_inf  = (&w_a_exp) && (w_a_man == '0);
    assign w_b_inf  = (&w_b_exp) && (w_b_man == '0);
    assign w_a_nan  = (&w_a_exp) && (w_a_man != '0);
    assign w_b_nan  = (&w_b_exp) && (w_b_man != '0);
    assign w_sign   = a[W-1] ^ b[W-1];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_s2_ready;
    logic w_s1_en;
    logic w_out_xfer;

    logic r_s1_valid;
    logic r_s2_valid;

    // Stage 2 can take new data when empty or when its content leaves now.
    assign w_s2_ready = !r_s2_valid || out_ready;
    // Stage 1 moves when empty or when its content drops into stage 2.
    assign w_s1_en    = !r_s1_valid || w_s2_ready;
    assign w_out_xfer = r_s2_valid && out_ready;
    // Gated by reset so nothing is offered as accepted while held in reset.
    assign in_ready   = rst_n && w_s1_en;

    // ------------------------------------------------------------------
    // Stage 1: classification and operand registers
    // ------------------------------------------------------------------
    logic         r_s1_nan;
    logic         r_s1_invalid;
    logic         r_s1_inf;
    logic         r_s1_zero;
    logic         r_s1_sign;
    logic [W-1:0] r_s1_zc;
    logic [2:0]   r_s1_round;
    logic         r_s1_inexact;

    // Capture a new operand set whenever stage 1 is free to move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_nan     <= 1'b0;
            r_s1_invalid <= 1'b0;
            r_s1_inf     <= 1'b0;
            r_s1_zero    <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_zc      <= '0;
            r_s1_round   <= 3'b000;
            r_s1_inexact <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_nan     <= w_a_nan || w_b_nan;
                r_s1_invalid <= (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf);
                r_s1_inf     <= w_a_inf || w_b_inf;
                r_s1_zero    <= w_a_zero || w_b_zero;
                r_s1_sign    <= w_sign;
                r_s1_zc      <= z_calc;
                r_s1_round   <= round;
                r_s1_inexact <= inexact_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 result selection
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] w_zc_exp;
    logic             w_zc_exp_max;
    logic             w_zc_exp_zero;
    logic             w_ovf_to_inf;
    logic [W-1:0]     w_inf_val;
    logic [W-1:0]     w_zero_val;
    logic [W-1:0]     w_max_finite;

    assign w_zc_exp      = r_s1_zc[W-2 -: EXP_W];
    assign w_zc_exp_max  = &w_zc_exp;
    assign w_zc_exp_zero = (w_zc_exp == '0);

    assign w_inf_val    = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign w_zero_val   = {r_s1_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    assign w_max_finite = {r_s1_sign, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    // Overflow rounds to infinity unless the mode rounds toward zero
    // for this sign; unused encodings behave as round-to-nearest-even.
    always_comb begin
        w_ovf_to_inf = 1'b1;
        case (r_s1_round)
            3'b001:  w_ovf_to_inf = 1'b0;
            3'b010:  w_ovf_to_inf = !r_s1_sign;
            3'b011:  w_ovf_to_inf = r_s1_sign;
            default: w_ovf_to_inf = 1'b1;
        endcase
    end

    logic [W-1:0] w_z;
    logic         w_ovf;
    logic         w_unf;
    logic         w_inexact;
    logic         w_st_zero;
    logic         w_st_inf;
    logic         w_st_nan;
    logic         w_st_invalid;
    logic [7:0]   w_status;

    // Priority chain: NaN, invalid, infinity, zero, overflow, underflow, normal.
    always_comb begin
        w_z          = r_s1_zc;
        w_ovf        = 1'b0;
        w_unf        = 1'b0;
        w_inexact    = r_s1_inexact;
        w_st_zero    = 1'b0;
        w_st_inf     = 1'b0;
        w_st_nan     = 1'b0;
        w_st_invalid = 1'b0;
        if (r_s1_nan) begin
            w_z       = QNAN;
            w_inexact = 1'b0;
            w_st_nan  = 1'b1;
        end else if (r_s1_invalid) begin
            w_z          = QNAN;
            w_inexact    = 1'b0;
            w_st_nan     = 1'b1;
            w_st_invalid = 1'b1;
        end else if (r_s1_inf) begin
            w_z       = w_inf_val;
            w_inexact = 1'b0;
            w_st_inf  = 1'b1;
        end else if (r_s1_zero) begin
            w_z       = w_zero_val;
            w_inexact = 1'b0;
            w_st_zero = 1'b1;
        end else if (w_zc_exp_max) begin
            w_ovf     = 1'b1;
            w_inexact = 1'b1;
            if (w_ovf_to_inf) begin
                w_z      = w_inf_val;
                w_st_inf = 1'b1;
            end else begin
                w_z = w_max_finite;
            end
        end else if (w_zc_exp_zero) begin
            w_z       = w_zero_val;
            w_unf     = 1'b1;
            w_inexact = 1'b1;
            w_st_zero = 1'b1;
        end
    end

    assign w_status = {1'b0, w_st_invalid, w_inexact, w_unf, w_ovf,
                       w_st_nan, w_st_inf, w_st_zero};

    // ------------------------------------------------------------------
    // Stage 2: output registers (held while the consumer stalls)
    // ------------------------------------------------------------------
    logic [W-1:0] r_z;
    logic         r_ovf;
    logic         r_unf;
    logic         r_inexact;
    logic [7:0]   r_status;

    // Load the result of stage 1 whenever stage 2 is free to move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_z        <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_inexact  <= 1'b0;
            r_status   <= 8'h00;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_z       <= w_z;
                r_ovf     <= w_ovf;
                r_unf     <= w_unf;
                r_inexact <= w_inexact;
                r_status  <= w_status;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky status
    // ------------------------------------------------------------------
    logic [7:0] r_sticky;

    // Accumulate on each output transfer; a clear coinciding with a
    // transfer keeps only the status of that transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 8'h00;
        end else if (w_out_xfer) begin
            r_sticky <= (sticky_clr ? 8'h00 : r_sticky) | r_status;
        end else if (sticky_clr) begin
            r_sticky <= 8'h00;
        end
    end

    assign out_valid     = r_s2_valid;
    assign z             = r_z;
    assign ovf           = r_ovf;
    assign unf           = r_unf;
    assign inexact       = r_inexact;
    assign status        = r_status;
    assign sticky_status = r_sticky;

endmodule

// File: tb/tb_exception_mult_pipe.sv
// Self-checking bench for exception_mult_pipe (binary32 configuration):
// directed cases, backpressure, sticky and reset behaviour, then random
// traffic checked against a behavioural model and an in-order scoreboard.
module tb_exception_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z_calc;
    logic [2:0]  round;
    logic        inexact_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic        ovf;
    logic        unf;
    logic        inexact;
    logic [7:0]  status;
    logic [7:0]  sticky_status;
    logic        sticky_clr;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] z;
        logic [7:0]  st;
    } exp_t;

    exp_t q[$];

    exception_mult_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .z_calc        (z_calc),
        .round         (round),
        .inexact_in    (inexact_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .z             (z),
        .ovf           (ovf),
        .unf           (unf),
        .inexact       (inexact),
        .status        (status),
        .sticky_status (sticky_status),
        .sticky_clr    (sticky_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: result and status from the rules, field by field.
    function automatic void ref_model(input logic [31:0] fa, input logic [31:0] fb,
                                      input logic [31:0] fzc, input logic [2:0] rm,
                                      input logic inx, output logic [31:0] ez,
                                      output logic [7:0] est);
        logic s;
        logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, to_inf;
        s      = fa[31] ^ fb[31];
        a_zero = (fa[30:23] == 8'd0);
        b_zero = (fb[30:23] == 8'd0);
        a_inf  = (fa[30:23] == 8'd255) && (fa[22:0] == 23'd0);
        b_inf  = (fb[30:23] == 8'd255) && (fb[22:0] == 23'd0);
        a_nan  = (fa[30:23] == 8'd255) && (fa[22:0] != 23'd0);
        b_nan  = (fb[30:23] == 8'd255) && (fb[22:0] != 23'd0);
        if (a_nan || b_nan) begin
            ez = 32'h7FC0_0000; est = 8'h04;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            ez = 32'h7FC0_0000; est = 8'h44;
        end else if (a_inf || b_inf) begin
            ez = {s, 31'h7F80_0000}; est = 8'h02;
        end else if (a_zero || b_zero) begin
            ez = {s, 31'h0}; est = 8'h01;
        end else if (fzc[30:23] == 8'd255) begin
            if (rm == 3'd1)      to_inf = 1'b0;
            else if (rm == 3'd2) to_inf = !s;
            else if (rm == 3'd3) to_inf = s;
            else                 to_inf = 1'b1;
            ez  = to_inf ? {s, 31'h7F80_0000} : {s, 31'h7F7F_FFFF};
            est = to_inf ? 8'h2A : 8'h28;
        end else if (fzc[30:23] == 8'd0) begin
            ez = {s, 31'h0}; est = 8'h31;
        end else begin
            ez = fzc; est = inx ? 8'h20 : 8'h00;
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0] e;
        case ($urandom_range(0, 5))
            0:       e = 8'd0;
            1:       return {1'($urandom), 8'hFF, 23'd0};
            2:       return {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    function automatic logic [31:0] rnd_zc();
        case ($urandom_range(0, 4))
            0:       return {1'($urandom), 8'd0, 23'($urandom)};
            1:       return {1'($urandom), 8'hFF, 23'd0};
            default: return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    // One isolated operation with out_ready high; checks latency and result,
    // and optionally asserts sticky_clr in the cycle of the output transfer.
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic [31:0] tzc, input logic [2:0] rm, input logic inx,
                         input logic clr, input logic [31:0] ez, input logic [7:0] est);
        a = ta; b = tb_; z_calc = tzc; round = rm; inexact_in = inx;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_z"}, z, ez);
        chk({tag, "_status"}, 32'(status), 32'(est));
        chk({tag, "_flags"}, {29'd0, inexact, unf, ovf}, {29'd0, est[5], est[4], est[3]});
        sticky_clr = clr;
        step();
        sticky_clr = 1'b0;
    endtask

    logic [31:0] bp_list [3];
    logic [31:0] mz;
    logic [7:0]  mst;
    logic [7:0]  exp_sticky;
    logic        hold_prev;
    logic [31:0] hold_z;
    logic [7:0]  hold_st;
    exp_t        e;
    int          got;
    logic        acc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; z_calc = '0; round = 3'd0;
        inexact_in = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_z", z, 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_sticky", 32'(sticky_status), 32'd0);
        chk("rst_flags", {29'd0, inexact, unf, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        step();

        // Directed cases
        do_op("normal", 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 3'd0, 1'b0, 1'b0,
              32'h4000_0000, 8'h00);
        do_op("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 32'h0, 3'd0, 1'b0, 1'b0,
              32'h7FC0_0000, 8'h44);
        do_op("nan", 32'hFFC0_0001, 32'h4000_0000, 32'h0, 3'd0, 1'b1, 1'b0,
              32'h7FC0_0000, 8'h04);
        do_op("nan_over_inv", 32'h7FC0_0000, 32'h0000_0000, 32'h0, 3'd0, 1'b0, 1'b0,
              32'h7FC0_0000, 8'h04);
        do_op("inf_x_norm", 32'hFF80_0000, 32'h4000_0000, 32'h4000_0000, 3'd0, 1'b1, 1'b0,
              32'hFF80_0000, 8'h02);
        do_op("zero_x_norm", 32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 3'd0, 1'b1, 1'b0,
              32'h8000_0000, 8'h01);
        do_op("ovf_rz", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'd1, 1'b0, 1'b0,
              32'h7F7F_FFFF, 8'h28);
        do_op("ovf_rne", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'd0, 1'b0, 1'b0,
              32'h7F80_0000, 8'h2A);
        do_op("ovf_neg_ru", 32'hFF00_0000, 32'h7F00_0000, 32'hFF80_0000, 3'd2, 1'b0, 1'b0,
              32'hFF7F_FFFF, 8'h28);
        do_op("ovf_neg_rd", 32'hFF00_0000, 32'h7F00_0000, 32'hFF80_0000, 3'd3, 1'b0, 1'b0,
              32'hFF80_0000, 8'h2A);
        do_op("ovf_rm7", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'd7, 1'b0, 1'b0,
              32'h7F80_0000, 8'h2A);
        do_op("unf", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'd0, 1'b0, 1'b0,
              32'h0000_0000, 8'h31);
        do_op("inexact", 32'h3F80_0000, 32'h4040_0000, 32'h4040_0000, 3'd0, 1'b1, 1'b0,
              32'h4040_0000, 8'h20);
        chk("sticky_accum", 32'(sticky_status), 32'h7F);

        // Sticky clear coinciding with transfers, and clear without transfer
        do_op("clr_ovf", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'd1, 1'b0, 1'b1,
              32'h7F7F_FFFF, 8'h28);
        chk("sticky_after_clr_ovf", 32'(sticky_status), 32'h28);
        do_op("clr_clean", 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 3'd0, 1'b0, 1'b1,
              32'h4000_0000, 8'h00);
        chk("sticky_after_clr_clean", 32'(sticky_status), 32'h00);
        do_op("ovf_again", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'd1, 1'b0, 1'b0,
              32'h7F7F_FFFF, 8'h28);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        chk("sticky_clr_idle", 32'(sticky_status), 32'h00);

        // Backpressure: three back-to-back inputs with the consumer stalled
        bp_list[0] = 32'h4040_0000;
        bp_list[1] = 32'h4080_0000;
        bp_list[2] = 32'h40A0_0000;
        a = 32'h3F80_0000; b = 32'h3F80_0000; round = 3'd0; inexact_in = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; z_calc = bp_list[0];
        step();
        z_calc = bp_list[1];
        step();
        z_calc = bp_list[2];
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_z", z, bp_list[0]);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && got < 3; c++) begin
            #1;
            if (out_valid) begin
                chk("bp_order", z, bp_list[got]);
                got++;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
        chk("bp_count", 32'(got), 32'd3);
        in_valid = 1'b0;

        // Reset in the middle of a stalled stream
        do_op("pre_rst_ovf", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'd1, 1'b0, 1'b0,
              32'h7F7F_FFFF, 8'h28);
        out_ready = 1'b0; in_valid = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sticky", 32'(sticky_status), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("post_rst_no_output", 32'(out_valid), 32'd0);
        end

        // Random traffic with random backpressure and sticky clears
        exp_sticky = 8'h00;
        hold_prev  = 1'b0;
        hold_z     = '0;
        hold_st    = '0;
        for (int c = 0; c < 3000; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            a          = rnd_op();
            b          = rnd_op();
            z_calc     = rnd_zc();
            round      = 3'($urandom);
            inexact_in = 1'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            sticky_clr = ($urandom_range(0, 15) == 0);
            #1;
            if (hold_prev) begin
                chk("rnd_hold_valid", 32'(out_valid), 32'd1);
                chk("rnd_hold_z", z, hold_z);
                chk("rnd_hold_status", 32'(status), 32'(hold_st));
            end
            if (in_valid && in_ready) begin
                ref_model(a, b, z_calc, round, inexact_in, mz, mst);
                q.push_back('{z: mz, st: mst});
            end
            if (out_valid && out_ready) begin
                chk("rnd_queue_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rnd_z", z, e.z);
                    chk("rnd_status", 32'(status), 32'(e.st));
                    chk("rnd_flags", {29'd0, inexact, unf, ovf},
                        {29'd0, e.st[5], e.st[4], e.st[3]});
                    exp_sticky = (sticky_clr ? 8'h00 : exp_sticky) | e.st;
                end
            end else if (sticky_clr) begin
                exp_sticky = 8'h00;
            end
            hold_prev = out_valid && !out_ready;
            hold_z    = z;
            hold_st   = status;
            step();
            chk("rnd_sticky", 32'(sticky_status), 32'(exp_sticky));
        end

        // Drain
        in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                chk("drain_queue_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("drain_z", z, e.z);
                    chk("drain_status", 32'(status), 32'(e.st));
                end
            end
            step();
        end
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exception_mult_pipe.md
EXCEPTION_MULT_PIPE -- requirements
Module: exception_mult_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width; W = 1+EXP_W+MAN_W.
REQ-002 Parameter MAN_W, default 23, mantissa field width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set a/b/z_calc/round/inexact_in valid.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 a, b  input  W  IEEE-style multiplier operands.
REQ-008 z_calc  input  W  datapath product, already rounded and exponent-saturated.
REQ-009 round  input  3  mode: 000 RNE, 001 RZ, 010 RU (+inf), 011 RD (-inf), 100 RNA; 101-111 treated as RNE.
REQ-010 inexact_in  input  1  datapath discarded nonzero bits.
REQ-011 out_valid  output  1  result valid; out_ready  input  1  consumer accepts.
REQ-012 z  output  W  final result.
REQ-013 ovf, unf, inexact  output  1 each  exception flags of current result.
REQ-014 status  output  8  [0] zero, [1] inf, [2] NaN, [3] ovf, [4] unf, [5] inexact, [6] invalid, [7] always 0.
REQ-015 sticky_status  output  8  OR of status over all completed transfers since reset/clear.
REQ-016 sticky_clr  input  1  synchronous clear of sticky_status.

Function
REQ-017 Classification per operand: zero = exp all-0 (subnormals flushed); inf = exp all-1, man 0; NaN = exp all-1, man nonzero.
REQ-018 Priority: any NaN -> z = {0, all-1, 1 followed by MAN_W-1 zeros} (qNaN), status[2].
REQ-019 Else inf x zero (either order) -> qNaN, status[2] and status[6] (invalid).
REQ-020 Else any inf -> z = {a[W-1]^b[W-1], all-1, 0}, status[1].
REQ-021 Else any zero -> z = {a[W-1]^b[W-1], 0, 0}, status[0].
REQ-022 Else z_calc exp all-1 -> overflow: ovf=1, inexact=1; sign s = a^b sign; result inf for RNE/RNA, RU with s=0, RD with s=1; otherwise max finite {s, all-1 except LSB 0, all-1}; status[1] set only if result inf.
REQ-023 Else z_calc exp all-0 -> underflow: z = {s, 0, 0}, unf=1, inexact=1, status[0]=1.
REQ-024 Else z = z_calc, inexact = inexact_in.
REQ-025 Special-input paths (REQ-018..021) drive ovf=unf=inexact=0.
REQ-026 Two-stage pipeline: stage 1 registers classification and operands; stage 2 registers z, flags, status; latency 2 cycles with out_ready held 1.
REQ-027 Transfer on valid&ready at each boundary; stage 2 loads when empty or out_ready=1; stage 1 loads when empty or stage 2 loads.
REQ-028 in_ready = stage 1 empty or stage 1 advances this cycle; full throughput of one result per cycle with no backpressure.
REQ-029 While out_valid=1 and out_ready=0, z, flags and status held stable; no result dropped, duplicated or reordered.
REQ-030 sticky_status |= status on each output transfer; sticky_clr without transfer -> 0; sticky_clr with transfer -> status of that transfer.

Reset
REQ-031 rst_n=0 clears both stage valids, out_valid, z, ovf, unf, inexact, status and sticky_status to 0 immediately, independent of clk.
REQ-032 in_ready is 0 while rst_n=0 and 1 in the first cycle after release.
REQ-033 Reset mid-operation discards all in-flight operations; none emerge after release.

Verification
REQ-034 a=0x3F800000, b=0x40000000, z_calc=0x40000000, inexact_in=0, out_ready=1 -> two cycles later z=0x40000000, status=0x00.
REQ-035 a=0x7F800000, b=0x00000000 -> z=0x7FC00000, status=0x44; a=0xFFC00001 -> z=0x7FC00000, status=0x04.
REQ-036 a=b=0x7F000000, z_calc=0x7F800000: round=001 -> z=0x7F7FFFFF, status=0x28; round=000 -> z=0x7F800000, status=0x2A; sign-negative, round=010 -> z=0xFF7FFFFF.
REQ-037 z_calc=0x00000000 with a=0x00800000, b=0x00800000 -> z=0x00000000, unf=1, status=0x31.
REQ-038 Three back-to-back inputs with out_ready=0 for 4 cycles -> in_ready low after 2 accepted, first result held stable, all three exit in order once out_ready=1.
REQ-039 Overflow transfer then sticky_clr coincident with a clean transfer -> sticky_status 0x28 then 0x00; rst_n pulse mid-stream -> out_valid=0, sticky_status=0x00.
